// File: rtl/result_checker_if.sv
// result_checker_if: expected-table load, result stream, run control and status of the result checker.
interface result_checker_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] result_in;
  logic             valid_in;
  logic             exp_wr_en;
  logic [4:0]       exp_wr_addr;
  logic [WIDTH-1:0] exp_wr_data;
  logic             start;
  logic             clear;
  logic             busy;
  logic             done;
  logic [5:0]       pass_count;
  logic [5:0]       fail_count;
  logic             all_pass;
  logic [4:0]       first_fail_idx;
  logic [WIDTH-1:0] first_fail_got;
  modport master (
    output result_in, valid_in, exp_wr_en, exp_wr_addr, exp_wr_data, start, clear,
    input  busy, done, pass_count, fail_count, all_pass, first_fail_idx, first_fail_got
  );
  modport slave (
    input  result_in, valid_in, exp_wr_en, exp_wr_addr, exp_wr_data, start, clear,
    output busy, done, pass_count, fail_count, all_pass, first_fail_idx, first_fail_got
  );
endinterface

// File: rtl/result_checker.sv
// result_checker: compares a stream of committed results against a preloaded expected-value table.
module result_checker #(
  parameter int NUM_CHECKS = 20,
  parameter int WIDTH      = 32
) (
  input logic            clk,
  input logic            reset,
  result_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [5:0] N    = 6'(NUM_CHECKS);
  localparam logic [4:0] LAST = 5'(NUM_CHECKS - 1);
  state_t           state, state_nx;
  logic [WIDTH-1:0] tbl [NUM_CHECKS];
  logic [4:0]       idx;
  logic [5:0]       pass_count, fail_count;
  logic [4:0]       first_fail_idx;
  logic [WIDTH-1:0] first_fail_got;
  logic             wr, hit, match;
  assign wr    = state == IDLE && bus.exp_wr_en && {1'b0, bus.exp_wr_addr} < N;
  assign hit   = state == RUN && bus.valid_in;
  assign match = bus.result_in == tbl[idx];
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && bus.start) state_nx = RUN;
    else if (hit && idx == LAST) state_nx = DONE;
    else if (state == DONE && bus.clear) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NUM_CHECKS; i++) tbl[i] <= '0;
    else if (wr) tbl[bus.exp_wr_addr] <= bus.exp_wr_data;
  // fail_count still zero marks the first mismatch, so capture happens only once per run
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      idx            <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
    end else if (state == IDLE && bus.start) begin
      idx            <= '0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
    end else if (hit) begin
      idx        <= idx + 5'd1;
      pass_count <= match ? pass_count + 6'd1 : pass_count;
      fail_count <= match ? fail_count : fail_count + 6'd1;
      if (!match && fail_count == '0) begin
        first_fail_idx <= idx;
        first_fail_got <= bus.result_in;
      end
    end
  assign bus.busy           = state == RUN;
  assign bus.done           = state == DONE;
  assign bus.all_pass       = state == DONE && fail_count == '0;
  assign bus.pass_count     = pass_count;
  assign bus.fail_count     = fail_count;
  assign bus.first_fail_idx = first_fail_idx;
  assign bus.first_fail_got = first_fail_got;
endmodule

// File: tb/tb_result_checker.sv
// tb_result_checker: directed steps with hand-computed expectations for result_checker.
module tb_result_checker;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] vals [20] = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h5, 32'h7, 32'h8, 32'hb, 32'h3, 32'hfffffffe,
                             32'h0, 32'h5, 32'h1, 32'hfffffff4, 32'h4d2, 32'hfffff8d7, 32'h1, 32'hfffffb2c,
                             32'h30, 32'h30};
  result_checker_if #(.WIDTH(32)) bus();
  result_checker #(.NUM_CHECKS(20), .WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.exp_wr_en = 1'b1;
    bus.exp_wr_addr = a;
    bus.exp_wr_data = d;
    step();
    bus.exp_wr_en = 1'b0;
  endtask
  task automatic go();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_busy", bus.busy, 1);
  endtask
  task automatic clr();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    chk("clear_done", bus.done, 0);
  endtask
  // mode 0: table values, 1: 0xDEAD at 9 and 0xBEEF at 13, 2: all zeros
  task automatic run_seq(input int mode, input bit gaps);
    for (int i = 0; i < 20; i++) begin
      if (gaps) begin
        bus.valid_in = 1'b0;
        step();
      end
      if (i == 19) chk("pre_done", bus.done, 0);
      bus.result_in = mode == 2 ? 32'h0 : (mode == 1 && i == 9) ? 32'hdead :
                      (mode == 1 && i == 13) ? 32'hbeef : vals[i];
      bus.valid_in = 1'b1;
      step();
      bus.valid_in = 1'b0;
    end
  endtask
  task automatic load_and_go();
    for (int i = 0; i < 19; i++) wr(5'(i), vals[i]);
    bus.exp_wr_en = 1'b1;
    bus.exp_wr_addr = 5'd19;
    bus.exp_wr_data = vals[19];
    bus.start = 1'b1;
    step();
    bus.exp_wr_en = 1'b0;
    bus.start = 1'b0;
    chk("load_start_busy", bus.busy, 1);
  endtask
  task automatic chk_all_pass(input string tag);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_pass"}, bus.pass_count, 20);
    chk({tag, "_fail"}, bus.fail_count, 0);
    chk({tag, "_all_pass"}, bus.all_pass, 1);
  endtask
  initial begin
    bus.result_in = '0;
    bus.valid_in = 1'b0;
    bus.exp_wr_en = 1'b0;
    bus.exp_wr_addr = '0;
    bus.exp_wr_data = '0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    step();
    step();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_all_pass", bus.all_pass, 0);
    chk("rst_pass", bus.pass_count, 0);
    chk("rst_fail", bus.fail_count, 0);
    chk("rst_ffi", bus.first_fail_idx, 0);
    chk("rst_ffg", bus.first_fail_got, 0);
    reset = 1'b1;
    step();
    load_and_go();
    run_seq(0, 1'b0);
    chk_all_pass("match");
    clr();
    chk("clear_holds_pass", bus.pass_count, 20);
    go();
    run_seq(1, 1'b0);
    chk("mm_done", bus.done, 1);
    chk("mm_pass", bus.pass_count, 18);
    chk("mm_fail", bus.fail_count, 2);
    chk("mm_ffi", bus.first_fail_idx, 9);
    chk("mm_ffg", bus.first_fail_got, 32'hdead);
    chk("mm_all_pass", bus.all_pass, 0);
    bus.start = 1'b1;
    bus.valid_in = 1'b1;
    bus.result_in = 32'h5;
    step();
    bus.start = 1'b0;
    bus.valid_in = 1'b0;
    chk("done_start_ign", bus.done, 1);
    chk("done_valid_ign", bus.fail_count, 2);
    chk("done_hold_pass", bus.pass_count, 18);
    clr();
    go();
    run_seq(0, 1'b1);
    chk_all_pass("gaps");
    clr();
    go();
    bus.exp_wr_en = 1'b1;
    bus.exp_wr_addr = 5'd3;
    bus.exp_wr_data = 32'h99;
    bus.clear = 1'b1;
    step();
    bus.exp_wr_en = 1'b0;
    bus.clear = 1'b0;
    chk("run_clear_ign", bus.busy, 1);
    chk("run_wr_no_count", bus.pass_count, 0);
    run_seq(0, 1'b0);
    chk_all_pass("run_wr_ign");
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("done_start_hold", bus.pass_count, 20);
    clr();
    chk("idle_busy", bus.busy, 0);
    go();
    for (int i = 0; i < 7; i++) begin
      bus.result_in = vals[i];
      bus.valid_in = 1'b1;
      step();
    end
    chk("mid_pass", bus.pass_count, 7);
    #1 reset = 1'b0;
    #1;
    chk("async_busy", bus.busy, 0);
    chk("async_pass", bus.pass_count, 0);
    chk("async_done", bus.done, 0);
    bus.valid_in = 1'b0;
    step();
    reset = 1'b1;
    step();
    go();
    run_seq(2, 1'b0);
    chk_all_pass("tbl_cleared");
    clr();
    load_and_go();
    run_seq(0, 1'b0);
    chk_all_pass("rerun");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
